// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FIFO entry widths, LCR bit positions,
// receiver state encodings and the character-timeout reload value.
package uart_receiver_pkg;

    localparam int unsigned UartFifoRecWidth = 11;
    localparam int unsigned UartFifoCounterW = 5;

    localparam int unsigned UartLcBits = 0;
    localparam int unsigned UartLcSb   = 2;
    localparam int unsigned UartLcPe   = 3;
    localparam int unsigned UartLcEp   = 4;
    localparam int unsigned UartLcSp   = 5;

    typedef enum logic [2:0] {
        SrIdle   = 3'd0,
        SrStart  = 3'd1,
        SrData   = 3'd2,
        SrParity = 3'd3,
        SrStop   = 3'd4,
        SrPush   = 3'd5
    } rstate_e;

    // 64 ticks per bit; the base of 7 counts start + 5 data + 1 stop bit.
    function automatic logic [9:0] toc_value(input logic [3:0] lcr_lo);
        logic [9:0] frame_bits;
        frame_bits = 10'd7 + 10'(lcr_lo[UartLcBits +: 2]) + 10'(lcr_lo[UartLcPe])
                   + 10'(lcr_lo[UartLcSb]);
        return (frame_bits << 6) - 10'd1;
    endfunction

endpackage

// File: rtl/uart_sync_flops.sv
// Multi-stage synchroniser for an asynchronous, idle-high input; flushes back to 1.
module uart_sync_flops #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else if (clear_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive half: oversampled deserialiser with parity/framing/break detection,
// RX FIFO push generation and the character-timeout down-counter.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        wb_rst_ni,
    input  logic [7:0]                  lcr,
    input  logic                        enable,
    input  logic                        rx_reset,
    input  logic                        srx_pad_i,
    input  logic                        rf_full,
    input  logic [UartFifoCounterW-1:0] rf_count,
    output logic                        rf_push,
    output logic [UartFifoRecWidth-1:0] rf_data_in,
    output logic                        rf_overrun,
    output logic [2:0]                  rstate,
    output logic [9:0]                  counter_t,
    output logic                        rf_timeout
);

    rstate_e                     state_q, state_d;
    logic [3:0]                  rcnt_q, rcnt_d;
    logic [7:0]                  shift_q, shift_d;
    logic [2:0]                  bidx_q, bidx_d;
    logic                        par_q, par_d;
    logic                        pe_q, pe_d;
    logic                        armed_q, armed_d;
    logic [UartFifoRecWidth-1:0] entry_q, entry_d;
    logic [9:0]                  elapsed_q, elapsed_d;

    logic       srx;
    logic [2:0] last_bit;
    logic       data_x, par_exp, stop_fe, stop_bi;
    logic [9:0] toc;
    logic       unused_lcr;

    uart_sync_flops #(
        .Stages (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .rst_ni  (wb_rst_ni),
        .clear_i (rx_reset),
        .d_i     (srx_pad_i),
        .q_o     (srx)
    );

    assign last_bit   = {1'b1, lcr[UartLcBits +: 2]};
    assign data_x     = ^shift_q;
    assign stop_fe    = ~srx;
    assign stop_bi    = stop_fe && (shift_q == 8'h00) && (!par_q || !lcr[UartLcPe]);
    assign unused_lcr = ^lcr[7:6];

    always_comb begin
        par_exp = 1'b0;
        case ({lcr[UartLcEp], lcr[UartLcSp]})
            2'b00:   par_exp = ~data_x;
            2'b01:   par_exp = 1'b1;
            2'b10:   par_exp = data_x;
            default: par_exp = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        shift_d = shift_q;
        bidx_d  = bidx_q;
        par_d   = par_q;
        pe_d    = pe_q;
        armed_d = armed_q;
        entry_d = entry_q;

        case (state_q)
            SrIdle: if (enable) begin
                // A break leaves the line low; only a high level re-arms start detection.
                if (srx) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = SrStart;
                    rcnt_d  = 4'd7;
                end
            end
            SrStart: if (enable) begin
                if (rcnt_q != 4'd0) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else if (srx) begin
                    state_d = SrIdle;
                end else begin
                    shift_d = 8'h00;
                    bidx_d  = 3'd0;
                    par_d   = 1'b0;
                    pe_d    = 1'b0;
                    rcnt_d  = 4'd15;
                    state_d = SrData;
                end
            end
            SrData: if (enable) begin
                if (rcnt_q != 4'd0) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else begin
                    shift_d[bidx_q] = srx;
                    rcnt_d          = 4'd15;
                    if (bidx_q == last_bit) begin
                        state_d = lcr[UartLcPe] ? SrParity : SrStop;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            SrParity: if (enable) begin
                if (rcnt_q != 4'd0) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else begin
                    par_d   = srx;
                    pe_d    = srx ^ par_exp;
                    rcnt_d  = 4'd15;
                    state_d = SrStop;
                end
            end
            SrStop: if (enable) begin
                if (rcnt_q != 4'd0) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else begin
                    entry_d = {shift_q, pe_q, stop_fe, stop_bi};
                    armed_d = 1'b0;
                    state_d = SrPush;
                end
            end
            SrPush:  state_d = SrIdle;
            default: state_d = SrIdle;
        endcase

        if (rx_reset) begin
            state_d = SrIdle;
            rcnt_d  = 4'd0;
            armed_d = 1'b1;
            entry_d = '0;
        end
    end

    // Timeout tracked as ticks elapsed so the reset value needs no lcr-dependent load.
    assign toc = toc_value(lcr[3:0]);

    always_comb begin
        elapsed_d = elapsed_q;
        if (rx_reset || rf_push || (rf_count == '0)) begin
            elapsed_d = 10'd0;
        end else if (enable && (elapsed_q < toc)) begin
            elapsed_d = elapsed_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= SrIdle;
            rcnt_q    <= 4'd0;
            shift_q   <= 8'h00;
            bidx_q    <= 3'd0;
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
            armed_q   <= 1'b1;
            entry_q   <= '0;
            elapsed_q <= 10'd0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            shift_q   <= shift_d;
            bidx_q    <= bidx_d;
            par_q     <= par_d;
            pe_q      <= pe_d;
            armed_q   <= armed_d;
            entry_q   <= entry_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign rf_push    = (state_q == SrPush) && !rf_full;
    assign rf_overrun = (state_q == SrPush) && rf_full;
    assign rf_data_in = entry_q;
    assign rstate     = state_q;
    assign counter_t  = (elapsed_q >= toc) ? 10'd0 : toc - elapsed_q;
    assign rf_timeout = (counter_t == 10'd0) && (rf_count != '0);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, expected FIFO entries
// are queued as each frame is sent and checked when the receiver pushes.
module tb_uart_receiver;

    localparam int unsigned Sync = 2;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [7:0]  lcr = 8'h03;
    logic        enable = 1'b1;
    logic        rx_reset = 1'b0;
    logic        srx_pad_i = 1'b1;
    logic        rf_full = 1'b0;
    logic [4:0]  rf_count = 5'd0;
    logic        rf_push;
    logic [10:0] rf_data_in;
    logic        rf_overrun;
    logic [2:0]  rstate;
    logic [9:0]  counter_t;
    logic        rf_timeout;

    int vectors = 0;
    int miscompares = 0;
    int push_cnt = 0;
    int ovr_cnt = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_exp;

    uart_receiver #(
        .SYNC_STAGES (Sync)
    ) dut (
        .clk        (clk),
        .wb_rst_ni  (wb_rst_ni),
        .lcr        (lcr),
        .enable     (enable),
        .rx_reset   (rx_reset),
        .srx_pad_i  (srx_pad_i),
        .rf_full    (rf_full),
        .rf_count   (rf_count),
        .rf_push    (rf_push),
        .rf_data_in (rf_data_in),
        .rf_overrun (rf_overrun),
        .rstate     (rstate),
        .counter_t  (counter_t),
        .rf_timeout (rf_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_rst_ni && rf_push) begin
            push_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_push: got %h, expected no push", rf_data_in);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rf_data_in !== mon_exp) begin
                    miscompares++;
                    $display("FAIL push_entry: got %h, expected %h", rf_data_in, mon_exp);
                end
            end
        end
        if (wb_rst_ni && rf_overrun) ovr_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par,
                              input logic stop_val, input logic lat_chk);
        int nbits;
        logic [7:0] d;
        logic x, par, pe, fe, bi;
        nbits = int'(lcr[1:0]) + 5;
        d  = data & (8'hFF >> (8 - nbits));
        x  = ^d;
        if (lcr[5]) par = ~lcr[4];
        else        par = lcr[4] ? x : ~x;
        par = par ^ bad_par;
        pe  = lcr[3] & bad_par;
        fe  = ~stop_val;
        bi  = fe && (d == 8'h00) && (!lcr[3] || !par);
        if (!rf_full) exp_q.push_back({d, pe, fe, bi});
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (lcr[3]) send_bit(par);
        srx_pad_i = stop_val;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (lat_chk && (i >= Sync + 8) && (i <= Sync + 10)) begin
                vectors++;
                if (rf_push !== (i == Sync + 9)) begin
                    miscompares++;
                    $display("FAIL push_latency clk %0d after stop: got %b, expected %b",
                             i, rf_push, (i == Sync + 9));
                end
            end
        end
        srx_pad_i = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] exp_toc[3];
        logic [7:0] lcrs[3];
        lcrs    = '{8'h03, 8'h0F, 8'h00};
        exp_toc = '{10'd639, 10'd767, 10'd447};
        #1;
        vectors++;
        if ({rstate, rf_push, rf_overrun, rf_data_in, rf_timeout} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got st=%0d push=%b ovr=%b data=%h to=%b, expected all 0",
                     rstate, rf_push, rf_overrun, rf_data_in, rf_timeout);
        end
        for (int i = 0; i < 3; i++) begin
            lcr = lcrs[i];
            #1;
            vectors++;
            if (counter_t !== exp_toc[i]) begin
                miscompares++;
                $display("FAIL reset_counter lcr=%h: got %0d, expected %0d",
                         lcr, counter_t, exp_toc[i]);
            end
        end
        lcr = 8'h03;
        @(negedge clk);
        wb_rst_ni = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        lcr = 8'h03;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        send_frame(8'hC9, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_parity();
        lcr = 8'h1B;
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
        lcr = 8'h0B;
        send_frame(8'h17, 1'b0, 1'b1, 1'b0);
        send_frame(8'h17, 1'b1, 1'b1, 1'b0);
        lcr = 8'h2B;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        lcr = 8'h3A;
        send_frame(8'h6C, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_frame_error();
        lcr = 8'h00;
        send_frame(8'h1F, 1'b0, 1'b0, 1'b0);
        lcr = 8'h01;
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
        lcr = 8'h03;
    endtask

    task automatic test_break();
        int p0;
        p0 = push_cnt;
        lcr = 8'h03;
        exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
        srx_pad_i = 1'b0;
        repeat (480) @(negedge clk);
        srx_pad_i = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h41, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ((push_cnt - p0) != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL break_pushes: got %0d pushes (%0d pending), expected 2 (0 pending)",
                     push_cnt - p0, exp_q.size());
        end
    endtask

    task automatic test_overrun_glitch();
        int p0, o0;
        p0 = push_cnt;
        o0 = ovr_cnt;
        rf_full = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        rf_full = 1'b0;
        vectors++;
        if ((ovr_cnt - o0) != 1 || (push_cnt - p0) != 0) begin
            miscompares++;
            $display("FAIL overrun: got %0d overrun clks, %0d pushes, expected 1 and 0",
                     ovr_cnt - o0, push_cnt - p0);
        end
        srx_pad_i = 1'b0;
        repeat (4) @(negedge clk);
        srx_pad_i = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (rstate !== 3'd0 || (push_cnt - p0) != 0) begin
            miscompares++;
            $display("FAIL glitch: got state %0d, %0d pushes, expected state 0, 0 pushes",
                     rstate, push_cnt - p0);
        end
    endtask

    task automatic test_timeout();
        lcr = 8'h03;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (counter_t !== 10'd639) begin
            miscompares++;
            $display("FAIL timeout_reload: got %0d, expected 639", counter_t);
        end
        rf_count = 5'd1;
        repeat (638) @(negedge clk);
        vectors++;
        if (counter_t !== 10'd1 || rf_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_before: got cnt=%0d to=%b, expected cnt=1 to=0",
                     counter_t, rf_timeout);
        end
        @(negedge clk);
        vectors++;
        if (counter_t !== 10'd0 || rf_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hit: got cnt=%0d to=%b, expected cnt=0 to=1",
                     counter_t, rf_timeout);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (counter_t !== 10'd0) begin
            miscompares++;
            $display("FAIL timeout_saturate: got %0d, expected 0", counter_t);
        end
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (counter_t < 10'd600 || rf_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_push_reload: got cnt=%0d to=%b, expected cnt>=600 to=0",
                     counter_t, rf_timeout);
        end
        rf_count = 5'd0;
    endtask

    task automatic test_rx_reset();
        rf_count = 5'd1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_reset = 1'b1;
        @(negedge clk);
        rx_reset  = 1'b0;
        srx_pad_i = 1'b1;
        vectors++;
        if (rstate !== 3'd0 || rf_data_in !== 11'd0 || counter_t !== 10'd639 || rf_push !== 1'b0)
        begin
            miscompares++;
            $display("FAIL rx_reset: got st=%0d data=%h cnt=%0d push=%b, expected 0/000/639/0",
                     rstate, rf_data_in, counter_t, rf_push);
        end
        repeat (200) @(negedge clk);
        rf_count = 5'd0;
    endtask

    task automatic test_async_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        rf_count = 5'd1;
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        wb_rst_ni = 1'b0;
        srx_pad_i = 1'b1;
        #1;
        vectors++;
        if (rstate !== 3'd0 || rf_data_in !== 11'd0 || counter_t !== 10'd639 ||
            rf_push !== 1'b0 || rf_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d data=%h cnt=%0d push=%b ovr=%b, expected 0/000/639/0/0",
                     rstate, rf_data_in, counter_t, rf_push, rf_overrun);
        end
        rf_count = 5'd0;
        @(negedge clk);
        wb_rst_ni = 1'b1;
        send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_error();
        test_break();
        test_overrun_glitch();
        test_timeout();
        test_rx_reset();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_entries: got %0d never pushed, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
